bsg_mem_1rw_sync_mask_write_byte_adapter: RTL and testbench



---
 rtl/bsg_mem_1rw_sync_mask_write_byte_adapter.sv | 93 +++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_byte_adapter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_adapter.sv
// bsg_mem_1rw_sync_mask_write_byte_adapter: byte-addressed load/store front-end for a 1rw sync byte-masked memory
module bsg_mem_1rw_sync_mask_write_byte_adapter #(
  parameter int els_p = 16,
  parameter int data_width_p = 64,
  localparam int lanes_lp = data_width_p / 8,
  localparam int addr_width_lp = (els_p <= 1) ? 1 : $clog2(els_p),
  localparam int offset_width_lp = (lanes_lp <= 1) ? 1 : $clog2(lanes_lp),
  localparam int size_width_lp = (offset_width_lp + 1 <= 1) ? 1 : $clog2(offset_width_lp + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     v_i,
  output logic                                     ready_o,
  input  logic                                     w_i,
  input  logic [addr_width_lp+offset_width_lp-1:0] addr_i,
  input  logic [size_width_lp-1:0]                 size_i,
  input  logic                                     signed_i,
  input  logic [data_width_p-1:0]                  data_i,
  output logic                                     mem_v_o,
  output logic                                     mem_w_o,
  output logic [addr_width_lp-1:0]                 mem_addr_o,
  output logic [data_width_p-1:0]                  mem_data_o,
  output logic [lanes_lp-1:0]                      mem_mask_o,
  input  logic [data_width_p-1:0]                  mem_data_i,
  output logic                                     v_o,
  output logic [data_width_p-1:0]                  data_o,
  input  logic                                     yumi_i
);
  logic [offset_width_lp-1:0] align_m, off, off_r;
  logic [size_width_lp-1:0] size_r;
  logic [offset_width_lp:0] nb;
  logic [lanes_lp-1:0] len_m;
  logic [data_width_p-1:0] shifted, res, entry0, entry1;
  logic [1:0] count;
  logic signed_r, inflight, sgn, accept;
  assign ready_o = ~reset_i & (((count + 2'(inflight)) < 2'd2) | yumi_i);
  assign accept = v_i & ready_o;
  assign mem_v_o = accept;
  assign mem_w_o = w_i;
  assign mem_addr_o = addr_i[addr_width_lp+offset_width_lp-1:offset_width_lp];
  assign v_o = count != 2'd0;
  assign data_o = entry0;
  // store side: aligned offset, byte mask and data replicated at the access size
  always_comb begin
    align_m = offset_width_lp'((1 << size_i) - 1);
    off = addr_i[offset_width_lp-1:0] & ~align_m;
    len_m = ~({lanes_lp{1'b1}} << (1 << size_i));
    mem_mask_o = len_m << off;
    mem_data_o = '0;
    for (int i = 0; i < lanes_lp; i++)
      mem_data_o[8*i+:8] = data_i[8*(i & ((1 << size_i) - 1))+:8];
  end
  // load side: shift the addressed bytes down and extend above the access size
  always_comb begin
    shifted = mem_data_i >> {off_r, 3'b000};
    nb = (offset_width_lp + 1)'(1) << size_r;
    sgn = signed_r & shifted[8*int'(nb)-1];
    res = '0;
    for (int i = 0; i < lanes_lp; i++)
      res[8*i+:8] = (i < int'(nb)) ? shifted[8*i+:8] : {8{sgn}};
  end
  // load tracking and the 2-entry in-order response buffer (entry0 is the head)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inflight <= 1'b0;
      count <= 2'd0;
    end else begin
      inflight <= accept & ~w_i;
      count <= count + 2'(inflight) - 2'(yumi_i);
      if (yumi_i) begin
        entry0 <= (count == 2'd2) ? entry1 : res;
        entry1 <= res;
      end else if (inflight) begin
        if (count == 2'd0) entry0 <= res;
        else entry1 <= res;
      end
    end
    if (accept & ~w_i) begin
      off_r <= off;
      size_r <= size_i;
      signed_r <= signed_i;
    end
  end
  // simulation-only checks on illegal use
  always @(posedge clk_i) begin
    assert (data_width_p % 8 == 0);
    if (!reset_i) begin
      if (accept) assert (32'(size_i) <= offset_width_lp);
      if (accept) assert ((addr_i[offset_width_lp-1:0] & align_m) == '0);
      if (yumi_i) assert (v_o);
    end
  end
endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_adapter.sv
// tb_bsg_mem_1rw_sync_mask_write_byte_adapter: directed checks of the byte adapter against a behavioural memory
module tb_bsg_mem_1rw_sync_mask_write_byte_adapter;
  logic clk = 0, reset_i = 1, v_i = 0, w_i = 0, signed_i = 0, yumi_man = 0, auto_yumi = 0;
  logic [6:0] addr_i = '0;
  logic [1:0] size_i = '0;
  logic [63:0] data_i = '0, mem_data_o, mem_data_i, data_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_mask_o;
  logic ready_o, mem_v_o, mem_w_o, v_o, yumi_i;
  logic [63:0] mem [16];
  int checks = 0, errors = 0;
  assign yumi_i = auto_yumi ? v_o : yumi_man;
  always #5 clk = ~clk;

  bsg_mem_1rw_sync_mask_write_byte_adapter #(.els_p(16), .data_width_p(64)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
    .addr_i(addr_i), .size_i(size_i), .signed_i(signed_i), .data_i(data_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  // behavioural synchronous byte-masked memory
  always @(posedge clk) begin
    if (mem_v_o && mem_w_o) begin
      for (int b = 0; b < 8; b++) if (mem_mask_o[b]) mem[mem_addr_o][8*b+:8] <= mem_data_o[8*b+:8];
    end else if (mem_v_o) mem_data_i <= mem[mem_addr_o];
  end

  function automatic logic [63:0] wv(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic store(input logic [6:0] a, input logic [1:0] s, input logic [63:0] d);
    @(negedge clk);
    v_i = 1; w_i = 1; addr_i = a; size_i = s; data_i = d;
    @(posedge clk);
    #1 v_i = 0;
  endtask

  task automatic load_one(input logic [6:0] a, input logic [1:0] s, input logic sg,
                          output logic [63:0] got, output logic on_time);
    logic early;
    @(negedge clk);
    v_i = 1; w_i = 0; addr_i = a; size_i = s; signed_i = sg;
    @(posedge clk);
    @(negedge clk);
    v_i = 0; early = v_o;
    @(negedge clk);
    got = data_o; on_time = v_o & ~early;
    yumi_man = v_o;
    @(negedge clk);
    yumi_man = 0;
  endtask

  task automatic test_reset();
    reset_i = 1; v_i = 1; w_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got %b exp 0", v_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_o); end
    checks++; if (mem_v_o !== 1'b0) begin errors++; $display("FAIL reset_mem_v got %b exp 0", mem_v_o); end
    v_i = 0; reset_i = 0;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", ready_o); end
  endtask

  task automatic test_full_word();
    logic [63:0] got; logic ok;
    @(negedge clk);
    v_i = 1; w_i = 1; addr_i = 7'h10; size_i = 3; data_i = 64'h1122334455667788;
    #1;
    checks++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b1) begin errors++; $display("FAIL st_mem_v got %b%b exp 11", mem_v_o, mem_w_o); end
    checks++; if (mem_addr_o !== 4'd2) begin errors++; $display("FAIL st_addr got %0d exp 2", mem_addr_o); end
    checks++; if (mem_mask_o !== 8'hFF) begin errors++; $display("FAIL st_mask got %h exp ff", mem_mask_o); end
    checks++; if (mem_data_o !== 64'h1122334455667788) begin errors++; $display("FAIL st_data got %h exp 1122334455667788", mem_data_o); end
    @(posedge clk);
    #1 v_i = 0;
    load_one(7'h10, 3, 0, got, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ld_full_latency got %b exp 1", ok); end
    checks++; if (got !== 64'h1122334455667788) begin errors++; $display("FAIL ld_full got %h exp 1122334455667788", got); end
  endtask

  task automatic test_byte();
    logic [63:0] got; logic ok;
    @(negedge clk);
    v_i = 1; w_i = 1; addr_i = 7'h13; size_i = 0; data_i = 64'h00000000000000AB;
    #1;
    checks++; if (mem_mask_o !== 8'h08) begin errors++; $display("FAIL byte_mask got %h exp 08", mem_mask_o); end
    checks++; if (mem_data_o !== 64'hABABABABABABABAB) begin errors++; $display("FAIL byte_data got %h exp abababababababab", mem_data_o); end
    @(posedge clk);
    #1 v_i = 0;
    load_one(7'h13, 0, 1, got, ok);
    checks++; if (got !== 64'hFFFFFFFFFFFFFFAB) begin errors++; $display("FAIL byte_signed got %h exp ffffffffffffffab", got); end
    load_one(7'h13, 0, 0, got, ok);
    checks++; if (got !== 64'h00000000000000AB) begin errors++; $display("FAIL byte_unsigned got %h exp ab", got); end
    load_one(7'h10, 3, 0, got, ok);
    checks++; if (got !== 64'h11223344AB667788) begin errors++; $display("FAIL byte_merge got %h exp 11223344ab667788", got); end
  endtask

  task automatic test_half();
    logic [63:0] got; logic ok;
    @(negedge clk);
    v_i = 1; w_i = 1; addr_i = 7'h06; size_i = 1; data_i = 64'h0000000000008001;
    #1;
    checks++; if (mem_mask_o !== 8'hC0) begin errors++; $display("FAIL half_mask got %h exp c0", mem_mask_o); end
    @(posedge clk);
    #1 v_i = 0;
    load_one(7'h06, 1, 1, got, ok);
    checks++; if (got !== 64'hFFFFFFFFFFFF8001) begin errors++; $display("FAIL half_signed got %h exp ffffffffffff8001", got); end
    load_one(7'h06, 1, 0, got, ok);
    checks++; if (got !== 64'h0000000000008001) begin errors++; $display("FAIL half_unsigned got %h exp 8001", got); end
    load_one(7'h04, 2, 1, got, ok);
    checks++; if (got !== 64'hFFFFFFFF80010000) begin errors++; $display("FAIL word_signed got %h exp ffffffff80010000", got); end
    load_one(7'h04, 2, 0, got, ok);
    checks++; if (got !== 64'h0000000080010000) begin errors++; $display("FAIL word_unsigned got %h exp 80010000", got); end
  endtask

  task automatic test_backpressure();
    int acc;
    logic r;
    for (int i = 0; i < 8; i++) store(7'(i * 8), 3, wv(i));
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v_i = 1; w_i = 0; addr_i = 7'(acc * 8); size_i = 3; signed_i = 0;
      #1 r = ready_o;
      @(posedge clk);
      if (r) acc++;
    end
    @(negedge clk);
    v_i = 0;
    checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", acc); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", ready_o); end
    checks++; if (v_o !== 1'b1 || data_o !== wv(0)) begin errors++; $display("FAIL bp_head got %b %h exp 1 %h", v_o, data_o, wv(0)); end
    yumi_man = 1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_on_yumi got %b exp 1", ready_o); end
    @(negedge clk);
    checks++; if (v_o !== 1'b1 || data_o !== wv(1)) begin errors++; $display("FAIL bp_second got %b %h exp 1 %h", v_o, data_o, wv(1)); end
    @(negedge clk);
    yumi_man = 0;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", v_o); end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    auto_yumi = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++; if (v_o !== 1'b1 || data_o !== wv(k - 2)) begin errors++; $display("FAIL stream_resp%0d got %b %h exp 1 %h", k - 2, v_o, data_o, wv(k - 2)); end
      end else begin
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL stream_early%0d got %b exp 0", k, v_o); end
      end
      if (v_o) seen++;
      v_i = k < 8; w_i = 0; addr_i = 7'(k * 8); size_i = 3; signed_i = 0;
      #1;
      if (k < 8) begin
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b exp 1", k, ready_o); end
      end
    end
    @(negedge clk);
    v_i = 0;
    checks++; if (v_o !== 1'b0 || seen !== 8) begin errors++; $display("FAIL stream_count got %b %0d exp 0 8", v_o, seen); end
    auto_yumi = 0;
  endtask

  task automatic test_reset_midflight();
    logic [63:0] got; logic ok;
    @(negedge clk);
    v_i = 1; w_i = 0; addr_i = 7'h08; size_i = 3; signed_i = 0;
    @(posedge clk);
    @(negedge clk);
    v_i = 0; reset_i = 1;
    #1;
    checks++; if (ready_o !== 1'b0 || v_o !== 1'b0) begin errors++; $display("FAIL mid_reset got ready %b v %b exp 0 0", ready_o, v_o); end
    @(negedge clk);
    reset_i = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL mid_ghost%0d got %b exp 0", k, v_o); end
      @(negedge clk);
    end
    load_one(7'h18, 3, 0, got, ok);
    checks++; if (ok !== 1'b1 || got !== wv(3)) begin errors++; $display("FAIL mid_next got %b %h exp 1 %h", ok, got, wv(3)); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_full_word();
    test_byte();
    test_half();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
